muldiv_sequencer: RTL and testbench

//  Iterative signed MULT/DIV engine sequenced by the main control FSM; owns the HI/LO registers.
//  The control FSM pulses start, waits for done, then reads hi/lo through the MemtoReg mux.
//  A single shared add/sub slice is reused every cycle. This keeps area low; the cost is latency.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_addsub.sv | 12 +
 rtl/muldiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative signed MULT/DIV sequencer.
package muldiv_pkg;
    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH) + 1;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        MD_IDLE    = 3'd0,
        MD_MULT    = 3'd1,
        MD_DIV     = 3'd2,
        MD_DIV_FIX = 3'd3,
        MD_DONE    = 3'd4
    } md_state_e;
endpackage

// File: rtl/muldiv_addsub.sv
// W-bit adder/subtractor with carry out; carry out on subtract means x >= y (unsigned).
module muldiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, x} + {1'b0, y ^ {W{sub}}} + {{W{1'b0}}, sub};
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) engine owning HI/LO.
// One add/sub slice is shared by both algorithms, one step per cycle.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: Booth accumulator (sign-extended) or division remainder
    logic [WIDTH:0]   acc_q, acc_d;
    // q: Booth multiplier or dividend shifting into quotient
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH:0]   as_x, as_y, as_s, booth_v;
    logic             as_sub, as_co;

    muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
        .x   (as_x),
        .y   (as_y),
        .sub (as_sub),
        .s   (as_s),
        .cout(as_co)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        as_x    = acc_q;
        as_y    = {m_q[WIDTH-1], m_q};
        as_sub  = 1'b0;
        booth_v = acc_q;

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    cnt_d = CNT_W'(WIDTH);
                    dz_d  = 1'b0;
                    acc_d = '0;
                    qm1_d = 1'b0;
                    if (op == MD_OP_MULT) begin
                        q_d     = b;
                        m_d     = a;
                        state_d = MD_MULT;
                    end else if (b == '0) begin
                        dz_d    = 1'b1;
                        state_d = MD_DONE;
                    end else begin
                        // Magnitudes; -2^(W-1) stays as an unsigned 2^(W-1)
                        q_d     = a[WIDTH-1] ? -a : a;
                        m_d     = b[WIDTH-1] ? -b : b;
                        sa_d    = a[WIDTH-1];
                        sb_d    = b[WIDTH-1];
                        state_d = MD_DIV;
                    end
                end
            end
            MD_MULT: begin
                as_sub  = q_q[0] & ~qm1_q;
                booth_v = (q_q[0] ^ qm1_q) ? as_s : acc_q;
                acc_d   = {booth_v[WIDTH], booth_v[WIDTH:1]};
                q_d     = {booth_v[0], q_q[WIDTH-1:1]};
                qm1_d   = q_q[0];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = acc_d[WIDTH-1:0];
                    lo_d    = q_d;
                    state_d = MD_DONE;
                end
            end
            MD_DIV: begin
                as_x   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
                as_y   = {1'b0, m_q};
                as_sub = 1'b1;
                acc_d  = as_co ? as_s : as_x;
                q_d    = {q_q[WIDTH-2:0], as_co};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = MD_DIV_FIX;
            end
            MD_DIV_FIX: begin
                lo_d    = (sa_q ^ sb_q) ? -q_q : q_q;
                hi_d    = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                state_d = MD_DONE;
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    assign busy     = (state_q == MD_MULT) || (state_q == MD_DIV) || (state_q == MD_DIV_FIX);
    assign done     = (state_q == MD_DONE);
    assign div_zero = (state_q == MD_DONE) && dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: latency, results, div-by-zero, ignored starts, reset abort.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    int          n_vec = 0;
    int          n_err = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Start sampled at edge 0; returns cycle index in which done was seen (0 = timeout).
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int ndone;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz",   64'(div_zero), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        // 7 * -3
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat);
        chk("mul1_lat", 64'(lat), 64'd33);
        chk("mul1_dz",  64'(div_zero), 64'd0);
        chk("mul1_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // -7 / 2
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
        chk("div1_lat", 64'(lat), 64'd34);
        chk("div1_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // 5 / 0: immediate done, hi/lo untouched
        run_op(1'b1, 32'd5, 32'd0, lat);
        chk("dz_lat", 64'(lat), 64'd1);
        chk("dz_flag", 64'(div_zero), 64'd1);
        chk("dz_hold", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk);
        chk("dz_clear", 64'(div_zero), 64'd0);

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("divmin_res", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat);
        chk("mulmin_res", {hi, lo}, 64'h4000_0000_0000_0000);
        run_op(1'b1, 32'd100, 32'hFFFF_FFF9, lat);
        chk("div2_res", {hi, lo}, 64'h0000_0002_FFFF_FFF2);
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, lat);
        chk("mul2_res", {hi, lo}, 64'h0000_0001_0000_0000);

        // Re-start during MULT and during DONE must be ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd100;
        @(negedge clk);
        start = 1'b0; a = 32'd9; b = 32'd9;
        lat = 0;
        for (int k = 6; k <= 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("busy_restart_lat", 64'(lat), 64'd33);
        chk("busy_restart_res", {hi, lo}, 64'd15);
        start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        chk("done_restart_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("done_restart_res", {hi, lo}, 64'd15);

        // Reset mid-MULT aborts with no done
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'd11; b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort_nodone", 64'(ndone), 64'd0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("post_abort_lat", 64'(lat), 64'd33);
        chk("post_abort_res", {hi, lo}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
